result_unloader: RTL and testbench

RESULT_UNLOADER -- requirements
Module: result_unloader

---
 rtl/tpu_pkg.sv | 8 +
 rtl/unloader_col_capture.sv | 56 +++++
 rtl/result_unloader.sv | 117 +++++++++++
 tb/tb_result_unloader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared fixed-point types, array defaults and unloader state encoding.
// Contents: N_DEFAULT (systolic dimension), FRAC_BITS (Q8.8), fixed16_t, unl_state_e.
package tpu_pkg;
    localparam int N_DEFAULT = 4;
    localparam int FRAC_BITS = 8;
    typedef logic signed [15:0] fixed16_t;
    typedef enum logic {FILL, DRAIN} unl_state_e;
endpackage

// File: rtl/unloader_col_capture.sv
// unloader_col_capture: one array column's row counter, write enable, accumulate adder and buffer.
// Ports: clk/rst; en (block in FILL); clr (zero buffer); done (tile complete, clear counter);
//        acc (accumulate instead of overwrite); valid/data (column element);
//        rd_row/rd_data (drain read port); wr (element accepted); drop (element rejected);
//        full_next (counter reaches N after this cycle).
module unloader_col_capture
    import tpu_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 done,
    input  logic                 acc,
    input  logic                 valid,
    input  logic [DATA_W-1:0]    data,
    input  logic [$clog2(N)-1:0] rd_row,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 wr,
    output logic                 drop,
    output logic                 full_next
);
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(N);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q [N];
    logic [RW-1:0]     wr_row;
    logic              full;

    assign full      = cnt_q == CW'(N);
    assign wr        = en && valid && !full;
    assign drop      = valid && (!en || full);
    // Looks ahead so the tile can complete in the same cycle as its last element.
    assign full_next = full || (wr && cnt_q == CW'(N - 1));
    assign cnt_d     = done ? '0 : cnt_q + CW'(wr);
    assign wr_row    = cnt_q[RW-1:0];
    assign rd_data   = buf_q[rd_row];

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Accumulate is a plain DATA_W two's-complement add: it wraps, never saturates.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else if (wr) begin
            buf_q[wr_row] <= acc ? buf_q[wr_row] + data : data;
        end
    end
endmodule

// File: rtl/result_unloader.sv
// result_unloader: collects an NxN result tile column-by-column from a systolic array,
// optionally accumulating onto buffered partial sums, then drains it row-major.
// Ports: clk/rst (sync, active high); col_valid/col_data (per-column elements, rows in order);
//        acc_mode/final_tile (sampled with a tile's first accepted element); in_ready (FILL);
//        out_valid/out_ready/out_data/out_row/out_col/out_last (drain stream);
//        err_drop (sticky: element arrived during DRAIN or into a full column).
module result_unloader
    import tpu_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         col_valid,
    input  logic [N*DATA_W-1:0]  col_data,
    input  logic                 acc_mode,
    input  logic                 final_tile,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last,
    output logic                 err_drop
);
    localparam int RW = $clog2(N);

    unl_state_e        state_q, state_d;
    logic              started_q, started_d, acc_q, acc_d, fin_q, fin_d, err_q, err_d;
    logic [RW-1:0]     row_q, row_d, col_q, col_d;
    logic [N-1:0]      wr, drop, full_next;
    logic [DATA_W-1:0] rd [N];
    logic              fill, tile_done, eff_acc, eff_fin, hs, clr, col_end, row_end;

    assign fill      = state_q == FILL;
    // Before a tile's first element is latched, the live mode inputs apply to that element.
    assign eff_acc   = started_q ? acc_q : acc_mode;
    assign eff_fin   = started_q ? fin_q : final_tile;
    assign tile_done = fill && &full_next;
    assign hs        = out_valid && out_ready;
    assign clr       = hs && out_last;
    assign col_end   = col_q == RW'(N - 1);
    assign row_end   = row_q == RW'(N - 1);

    for (genvar j = 0; j < N; j++) begin : g_col
        unloader_col_capture #(.N(N), .DATA_W(DATA_W)) u_col (
            .clk       (clk),
            .rst       (rst),
            .en        (fill),
            .clr       (clr),
            .done      (tile_done),
            .acc       (eff_acc),
            .valid     (col_valid[j]),
            .data      (col_data[j*DATA_W +: DATA_W]),
            .rd_row    (row_q),
            .rd_data   (rd[j]),
            .wr        (wr[j]),
            .drop      (drop[j]),
            .full_next (full_next[j])
        );
    end

    assign in_ready  = fill;
    assign out_valid = !fill;
    assign out_data  = out_valid ? rd[col_q] : '0;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = out_valid && row_end && col_end;
    assign err_drop  = err_q;

    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        acc_d     = acc_q;
        fin_d     = fin_q;
        row_d     = row_q;
        col_d     = col_q;
        err_d     = err_q || |drop;
        if (fill) begin
            if (!started_q && |wr) begin
                started_d = 1'b1;
                acc_d     = acc_mode;
                fin_d     = final_tile;
            end
            if (tile_done) begin
                started_d = 1'b0;
                state_d   = eff_fin ? DRAIN : FILL;
            end
        end else if (hs) begin
            col_d   = col_end ? '0 : col_q + 1'b1;
            row_d   = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
            state_d = out_last ? FILL : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            started_q <= 1'b0;
            acc_q     <= 1'b0;
            fin_q     <= 1'b0;
            err_q     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            acc_q     <= acc_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end
endmodule

// File: tb/tb_result_unloader.sv
// tb_result_unloader: directed table-driven checks of result_unloader with N=2 plus a mid-drain reset sequence.
module tb_result_unloader;
    import tpu_pkg::*;

    localparam int N  = 2;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   col_valid = '0;
    logic [N*DW-1:0] col_data = '0;
    logic           acc_mode = 1'b0;
    logic           final_tile = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready, out_valid, out_last, err_drop;
    logic [DW-1:0]  out_data;
    logic           out_row, out_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_unloader #(.N(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .col_valid  (col_valid),
        .col_data   (col_data),
        .acc_mode   (acc_mode),
        .final_tile (final_tile),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .err_drop   (err_drop)
    );

    typedef struct {
        logic [1:0] cv;
        fixed16_t   d1, d0;
        logic       acc, fin, ordy;
        logic       ir, ov;
        fixed16_t   od;
        logic       r, c, last, err;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(logic [1:0] cv, fixed16_t d1, fixed16_t d0, logic acc, logic fin,
                                logic ordy, logic ir, logic ov, fixed16_t od, logic r, logic c,
                                logic last, logic err);
        vec_t x;
        x.cv = cv; x.d1 = d1; x.d0 = d0; x.acc = acc; x.fin = fin; x.ordy = ordy;
        x.ir = ir; x.ov = ov; x.od = od; x.r = r; x.c = c; x.last = last; x.err = err;
        return x;
    endfunction

    task automatic drive(logic [1:0] cv, fixed16_t d1, fixed16_t d0, logic acc, logic fin, logic ordy);
        @(negedge clk);
        col_valid  = cv;
        col_data   = {d1, d0};
        acc_mode   = acc;
        final_tile = fin;
        out_ready  = ordy;
        #1;
    endtask

    task automatic check(string name, fixed16_t od, logic ir, logic ov, logic r, logic c, logic last, logic err);
        checks++;
        if ({out_data, in_ready, out_valid, out_row, out_col, out_last, err_drop} !==
            {od, ir, ov, r, c, last, err}) begin
            errors++;
            $display("FAIL %s: got data=%h rdy=%b v=%b row=%0d col=%0d last=%b err=%b, want data=%h rdy=%b v=%b row=%0d col=%0d last=%b err=%b",
                     name, out_data, in_ready, out_valid, out_row, out_col, out_last, err_drop,
                     od, ir, ov, r, c, last, err);
        end
    endtask

    initial begin
        //          cv     d1        d0        acc fin rdy  ir ov od        r  c  last err
        // skewed overwrite, final tile
        v.push_back(mk(2'b01, 16'h0000, 16'h0100, 0, 1, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'hFF00, 16'h0180, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b10, 16'h0200, 16'h0000, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0100, 0, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'hFF00, 0, 1, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0180, 1, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0200, 1, 1, 1, 0));
        // tile A overwrite non-final, tile B accumulate final (modes taken from first element)
        v.push_back(mk(2'b11, 16'h0100, 16'h0100, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'h0100, 16'h0100, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'h0080, 16'h0080, 1, 1, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'h0080, 16'h0080, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        // drain with backpressure on element 2
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0180, 0, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 0,  0, 1, 16'h0180, 0, 1, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 0,  0, 1, 16'h0180, 0, 1, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 0,  0, 1, 16'h0180, 0, 1, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0180, 0, 1, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0180, 1, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0180, 1, 1, 1, 0));
        // accumulate wrap: 0x7F00 + 0x0200 = 0x8100
        v.push_back(mk(2'b11, 16'h7F00, 16'h7F00, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'h0000, 16'h0000, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'h0200, 16'h0200, 1, 1, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b11, 16'h0100, 16'h0100, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h8100, 0, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h8100, 0, 1, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0100, 1, 0, 0, 0));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h0100, 1, 1, 1, 0));
        // extra element into full column 0, then elements during drain
        v.push_back(mk(2'b01, 16'h0000, 16'h1111, 0, 1, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b01, 16'h0000, 16'h2222, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b01, 16'h0000, 16'h3333, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0));
        v.push_back(mk(2'b10, 16'h4444, 16'h0000, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 1));
        v.push_back(mk(2'b10, 16'h5555, 16'h0000, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 1));
        v.push_back(mk(2'b11, 16'hAAAA, 16'hBBBB, 0, 0, 1,  0, 1, 16'h1111, 0, 0, 0, 1));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h4444, 0, 1, 0, 1));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h2222, 1, 0, 0, 1));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 1,  0, 1, 16'h5555, 1, 1, 1, 1));
        v.push_back(mk(2'b00, 16'h0000, 16'h0000, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (v[i]) begin
            drive(v[i].cv, v[i].d1, v[i].d0, v[i].acc, v[i].fin, v[i].ordy);
            check($sformatf("vec%0d", i), v[i].od, v[i].ir, v[i].ov, v[i].r, v[i].c, v[i].last, v[i].err);
        end

        // reset mid-drain, with a simultaneous handshake and column traffic
        drive(2'b11, 16'h0B00, 16'h0A00, 0, 1, 1);
        drive(2'b11, 16'h0D00, 16'h0C00, 0, 0, 1);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        check("pre_rst_e0", 16'h0A00, 0, 1, 0, 0, 0, 1);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        check("pre_rst_e1", 16'h0B00, 0, 1, 0, 1, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        col_valid = 2'b11;
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        rst = 1'b0;
        check("post_rst", 16'h0000, 1, 0, 0, 0, 0, 0);

        // fresh tile in accumulate mode: outputs equal inputs only if the buffer was zeroed
        drive(2'b11, 16'h0200, 16'h0100, 1, 1, 1);
        drive(2'b11, 16'h0400, 16'h0300, 0, 0, 1);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        begin
            int k = 0;
            while (!out_valid && k < 8) begin
                @(negedge clk);
                #1;
                k++;
            end
            checks++;
            if (!out_valid) begin
                errors++;
                $display("FAIL fresh_wait: out_valid=%b after %0d cycles, want 1", out_valid, k);
            end
        end
        check("fresh_e0", 16'h0100, 0, 1, 0, 0, 0, 0);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        check("fresh_e1", 16'h0200, 0, 1, 0, 1, 0, 0);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        check("fresh_e2", 16'h0300, 0, 1, 1, 0, 0, 0);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        check("fresh_e3", 16'h0400, 0, 1, 1, 1, 1, 0);
        drive(2'b00, 16'h0000, 16'h0000, 0, 0, 0);
        check("fresh_idle", 16'h0000, 1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
